// File: rtl/pwm_reg_pkg.sv
// Register offsets, widths and the per-channel config type shared by the PWM core
// and its channel instances.
package pwm_reg_pkg;

   localparam int PWM_CTRL_OFFSET        = 'h00;
   localparam int PWM_PRESC_OFFSET       = 'h04;
   localparam int PWM_INTR_STATE_OFFSET  = 'h08;
   localparam int PWM_INTR_ENABLE_OFFSET = 'h0C;
   localparam int PWM_CH_BASE            = 'h10;
   localparam int PWM_CH_STRIDE          = 8;
   localparam int PWM_DUTY_SUBOFF        = 4;

   localparam int PWM_PRESC_W  = 16;
   // Config fields are carried at the widest legal counter width; channels slice down.
   localparam int PWM_CNT_MAXW = 32;

   typedef struct packed {
      logic [PWM_CNT_MAXW-1:0] period;
      logic [PWM_CNT_MAXW-1:0] duty;
   } pwm_ch_cfg_t;

   function automatic int pwm_ch_offset(input int ch, input bit is_duty);
      return PWM_CH_BASE + ch * PWM_CH_STRIDE + (is_duty ? PWM_DUTY_SUBOFF : 0);
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: period counter, active period/duty copies and the output flop.
// Pending values are taken while disabled and at every period wrap.
module pwm_channel import pwm_reg_pkg::*; #(
   parameter int CntW = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic        tick_i,
   input  pwm_ch_cfg_t cfg_i,
   output logic        pwm_o,
   output logic        wrap_o
);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] per_q, per_d;
   logic [CntW-1:0] duty_q, duty_d;
   logic            pwm_q, pwm_d;
   logic [CntW-1:0] per_new, duty_new;
   logic            unused_cfg;

   assign per_new    = cfg_i.period[CntW-1:0];
   assign duty_new   = cfg_i.duty[CntW-1:0];
   assign unused_cfg = ^cfg_i;

   assign wrap_o = en_i && tick_i && (cnt_q == per_q);

   always_comb begin
      cnt_d  = cnt_q;
      per_d  = per_q;
      duty_d = duty_q;
      // cnt <= per_q always holds, so cnt < duty covers both duty=0 and duty>period.
      pwm_d  = en_i && (cnt_q < duty_q);
      if (!en_i) begin
         cnt_d  = '0;
         per_d  = per_new;
         duty_d = duty_new;
      end else if (tick_i) begin
         if (cnt_q == per_q) begin
            cnt_d  = '0;
            per_d  = per_new;
            duty_d = duty_new;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         per_q  <= '0;
         duty_q <= '0;
         pwm_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         per_q  <= per_d;
         duty_q <= duty_d;
         pwm_q  <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_core.sv
// PWM register file, shared prescaler and interrupt logic driving NCh pwm_channel
// instances. Reads are combinational off addr_i while re_i is high.
module pwm_core import pwm_reg_pkg::*; #(
   parameter int NCh   = 4,
   parameter int CntW  = 16,
   parameter int RegAw = 8,
   parameter int RegDw = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             re_i,
   input  logic             we_i,
   input  logic [RegAw-1:0] addr_i,
   input  logic [RegDw-1:0] wdata_i,
   output logic [RegDw-1:0] rdata_o,
   output logic [NCh-1:0]   pwm_o,
   output logic             intr_o
);

   logic [RegAw-1:0] waddr;
   logic             sel_ctrl, sel_presc, sel_ist, sel_ien;
   logic [NCh-1:0]   sel_per, sel_duty;

   logic [NCh-1:0]            ctrl_q, ctrl_d;
   logic [NCh-1:0]            ist_q, ist_d;
   logic [NCh-1:0]            ien_q, ien_d;
   logic [PWM_PRESC_W-1:0]    presc_q, presc_d;
   logic [PWM_PRESC_W-1:0]    pre_cnt_q, pre_cnt_d;
   logic [NCh-1:0][CntW-1:0]  per_q, per_d;
   logic [NCh-1:0][CntW-1:0]  duty_q, duty_d;
   logic                      intr_q, intr_d;

   logic                      any_en, tick;
   logic [NCh-1:0]            wrap;
   logic [NCh-1:0]            w1c;
   pwm_ch_cfg_t [NCh-1:0]     cfg;
   logic                      unused_bits;

   assign waddr       = {addr_i[RegAw-1:2], 2'b00};
   assign unused_bits = ^{wdata_i, addr_i[1:0]};

   always_comb begin
      sel_ctrl  = (waddr == RegAw'(PWM_CTRL_OFFSET));
      sel_presc = (waddr == RegAw'(PWM_PRESC_OFFSET));
      sel_ist   = (waddr == RegAw'(PWM_INTR_STATE_OFFSET));
      sel_ien   = (waddr == RegAw'(PWM_INTR_ENABLE_OFFSET));
      sel_per   = '0;
      sel_duty  = '0;
      for (int ch = 0; ch < NCh; ch++) begin
         sel_per[ch]  = (waddr == RegAw'(pwm_ch_offset(ch, 1'b0)));
         sel_duty[ch] = (waddr == RegAw'(pwm_ch_offset(ch, 1'b1)));
      end
   end

   // Prescaler only runs while some channel is enabled; a P shrunk below pre_cnt wraps.
   assign any_en = |ctrl_q;
   assign tick   = any_en && (pre_cnt_q == presc_q);

   always_comb begin
      if (!any_en || (pre_cnt_q >= presc_q)) pre_cnt_d = '0;
      else                                   pre_cnt_d = pre_cnt_q + PWM_PRESC_W'(1);
   end

   always_comb begin
      ctrl_d  = ctrl_q;
      presc_d = presc_q;
      ien_d   = ien_q;
      per_d   = per_q;
      duty_d  = duty_q;
      if (we_i) begin
         if (sel_ctrl)  ctrl_d  = wdata_i[NCh-1:0];
         if (sel_presc) presc_d = wdata_i[PWM_PRESC_W-1:0];
         if (sel_ien)   ien_d   = wdata_i[NCh-1:0];
         for (int ch = 0; ch < NCh; ch++) begin
            if (sel_per[ch])  per_d[ch]  = wdata_i[CntW-1:0];
            if (sel_duty[ch]) duty_d[ch] = wdata_i[CntW-1:0];
         end
      end
      // A wrap set beats a same-cycle W1C on the same bit.
      w1c    = (we_i && sel_ist) ? wdata_i[NCh-1:0] : '0;
      ist_d  = (ist_q & ~w1c) | wrap;
      intr_d = |(ist_d & ien_d);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctrl_q    <= '0;
         presc_q   <= '0;
         pre_cnt_q <= '0;
         ist_q     <= '0;
         ien_q     <= '0;
         per_q     <= '0;
         duty_q    <= '0;
         intr_q    <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         presc_q   <= presc_d;
         pre_cnt_q <= pre_cnt_d;
         ist_q     <= ist_d;
         ien_q     <= ien_d;
         per_q     <= per_d;
         duty_q    <= duty_d;
         intr_q    <= intr_d;
      end
   end

   always_comb begin
      rdata_o = '0;
      if (re_i) begin
         if (sel_ctrl)  rdata_o = RegDw'(ctrl_q);
         if (sel_presc) rdata_o = RegDw'(presc_q);
         if (sel_ist)   rdata_o = RegDw'(ist_q);
         if (sel_ien)   rdata_o = RegDw'(ien_q);
         for (int ch = 0; ch < NCh; ch++) begin
            if (sel_per[ch])  rdata_o = RegDw'(per_q[ch]);
            if (sel_duty[ch]) rdata_o = RegDw'(duty_q[ch]);
         end
      end
   end

   for (genvar ch = 0; ch < NCh; ch++) begin : g_ch
      assign cfg[ch] = '{period: PWM_CNT_MAXW'(per_q[ch]), duty: PWM_CNT_MAXW'(duty_q[ch])};

      pwm_channel #(.CntW(CntW)) u_ch (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .en_i   (ctrl_q[ch]),
         .tick_i (tick),
         .cfg_i  (cfg[ch]),
         .pwm_o  (pwm_o[ch]),
         .wrap_o (wrap[ch])
      );
   end

   assign intr_o = intr_q;

endmodule

// File: tb/tb_pwm_core.sv
// Randomized and directed checks of pwm_core against a cycle-level reference model
// built from the register map and PWM rules.
module tb_pwm_core;

   localparam int NCH  = 4;
   localparam int CNTW = 16;
   localparam int CMSK = (1 << CNTW) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             re = 1'b0, we = 1'b0;
   logic [7:0]       addr = '0;
   logic [31:0]      wdata = '0;
   logic [31:0]      rdata;
   logic [NCH-1:0]   pwm;
   logic             intr;

   int total = 0;
   int bad   = 0;

   pwm_core #(.NCh(NCH), .CntW(CNTW), .RegAw(8), .RegDw(32)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .re_i    (re),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .pwm_o   (pwm),
      .intr_o  (intr)
   );

   always #5 clk = ~clk;

   // Reference model state (plain integers)
   int m_ctrl, m_presc, m_ist, m_ien, m_pre;
   int m_per[NCH], m_duty[NCH], m_cnt[NCH], m_pa[NCH], m_da[NCH];
   logic [NCH-1:0] m_pwm;
   logic           m_intr;

   task automatic model_reset();
      m_ctrl = 0; m_presc = 0; m_ist = 0; m_ien = 0; m_pre = 0;
      for (int c = 0; c < NCH; c++) begin
         m_per[c] = 0; m_duty[c] = 0; m_cnt[c] = 0; m_pa[c] = 0; m_da[c] = 0;
      end
      m_pwm = '0; m_intr = 1'b0;
   endtask

   function automatic logic [31:0] m_read(input logic [7:0] a);
      int wa;
      wa = int'({a[7:2], 2'b00});
      if (wa == 'h00) return 32'(m_ctrl);
      if (wa == 'h04) return 32'(m_presc);
      if (wa == 'h08) return 32'(m_ist);
      if (wa == 'h0C) return 32'(m_ien);
      if (wa >= 'h10 && wa < 'h10 + 8 * NCH)
         return (wa % 8 == 0) ? 32'(m_per[(wa - 'h10) / 8]) : 32'(m_duty[(wa - 'h10) / 8]);
      return 32'h0;
   endfunction

   // Advance the model by one clock edge using the inputs presented for that edge.
   task automatic model_edge();
      bit tick, en;
      int wa, clr, wrapped;
      tick = (m_ctrl != 0) && (m_pre == m_presc);
      wrapped = 0;
      for (int c = 0; c < NCH; c++) begin
         en = ((m_ctrl >> c) & 1) != 0;
         m_pwm[c] = en && (m_cnt[c] < m_da[c]);
         if (!en || (tick && m_cnt[c] == m_pa[c])) begin
            if (en) wrapped |= (1 << c);
            m_cnt[c] = 0; m_pa[c] = m_per[c]; m_da[c] = m_duty[c];
         end else if (tick) begin
            m_cnt[c] = m_cnt[c] + 1;
         end
      end
      m_pre = (m_ctrl == 0 || m_pre >= m_presc) ? 0 : m_pre + 1;
      clr = 0;
      if (we) begin
         wa = int'({addr[7:2], 2'b00});
         if (wa == 'h00) m_ctrl = int'(wdata[NCH-1:0]);
         else if (wa == 'h04) m_presc = int'(wdata[15:0]);
         else if (wa == 'h08) clr = int'(wdata[NCH-1:0]);
         else if (wa == 'h0C) m_ien = int'(wdata[NCH-1:0]);
         else if (wa >= 'h10 && wa < 'h10 + 8 * NCH) begin
            if (wa % 8 == 0) m_per[(wa - 'h10) / 8]  = int'(wdata) & CMSK;
            else             m_duty[(wa - 'h10) / 8] = int'(wdata) & CMSK;
         end
      end
      m_ist  = (m_ist & ~clr) | wrapped;
      m_intr = (m_ist & m_ien) != 0;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wdata = d;
      step();
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] v);
      re = 1'b1; addr = a;
      #1;
      v = rdata;
      step();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] v, e;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (pwm !== '0 || intr !== 1'b0) begin
         bad++; $display("FAIL reset_in: got pwm=%b intr=%b want 0 0", pwm, intr);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         e = 32'h0;
         rd(8'(i * 4), v);
         total++;
         if (v !== e) begin
            bad++; $display("FAIL reset_reg 0x%0h: got %0h want %0h", i * 4, v, e);
         end
      end
   endtask

   task automatic test_basic();
      logic e;
      logic [31:0] v;
      wr(8'h04, 0); wr(8'h10, 3); wr(8'h14, 2); wr(8'h00, 1);
      for (int i = 0; i < 12; i++) begin
         step();
         e = (i % 4) < 2;
         total++;
         if (pwm[0] !== e || pwm !== m_pwm || intr !== m_intr) begin
            bad++; $display("FAIL basic cyc %0d: got pwm=%b intr=%b want pwm0=%b pwm=%b intr=%b",
                            i, pwm, intr, e, m_pwm, m_intr);
         end
      end
      rd(8'h08, v);
      total++;
      if (v !== 32'h1) begin
         bad++; $display("FAIL basic_ist: got %0h want 1", v);
      end
   endtask

   task automatic test_intr();
      logic [31:0] v;
      wr(8'h0C, 1);
      total++;
      if (intr !== 1'b1) begin bad++; $display("FAIL intr_en: got %b want 1", intr); end
      for (int k = 0; k < 10 && m_cnt[0] != 0; k++) step();
      wr(8'h08, 1);
      total++;
      if (intr !== 1'b0) begin bad++; $display("FAIL intr_clr: got %b want 0", intr); end
      for (int k = 0; k < 10 && m_cnt[0] != 3; k++) begin
         step();
         total++;
         if (intr !== m_intr) begin bad++; $display("FAIL intr_wait: got %b want %b", intr, m_intr); end
      end
      total++;
      if (m_cnt[0] != 3) begin bad++; $display("FAIL intr_sync: got cnt=%0d want 3", m_cnt[0]); end
      wr(8'h08, 1);
      total++;
      if (intr !== 1'b1) begin bad++; $display("FAIL intr_w1c_wrap: got %b want 1", intr); end
      rd(8'h08, v);
      total++;
      if (v !== 32'h1) begin bad++; $display("FAIL intr_w1c_state: got %0h want 1", v); end
   endtask

   task automatic test_shadow();
      logic exp_seq [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 10 && m_cnt[0] != 1; k++) step();
      wr(8'h14, 1);
      total++;
      if (pwm[0] !== 1'b1) begin bad++; $display("FAIL shadow_now: got %b want 1", pwm[0]); end
      for (int i = 0; i < 6; i++) begin
         step();
         total++;
         if (pwm[0] !== exp_seq[i] || pwm !== m_pwm) begin
            bad++; $display("FAIL shadow cyc %0d: got %b want %b (model %b)", i, pwm[0], exp_seq[i], m_pwm[0]);
         end
      end
      wr(8'h14, 0);
      repeat (8) step();
      for (int i = 0; i < 8; i++) begin
         step();
         total++;
         if (pwm[0] !== 1'b0 || pwm !== m_pwm) begin
            bad++; $display("FAIL duty_zero cyc %0d: got %b want 0", i, pwm[0]);
         end
      end
      wr(8'h14, 5);
      repeat (8) step();
      for (int i = 0; i < 8; i++) begin
         step();
         total++;
         if (pwm[0] !== 1'b1 || pwm !== m_pwm) begin
            bad++; $display("FAIL duty_over cyc %0d: got %b want 1", i, pwm[0]);
         end
      end
   endtask

   task automatic test_presc();
      logic e;
      apply_reset();
      wr(8'h04, 2); wr(8'h18, 1); wr(8'h1C, 1); wr(8'h00, 2);
      for (int i = 0; i < 12; i++) begin
         step();
         e = ((i / 3) % 2) == 0;
         total++;
         if (pwm[1] !== e || pwm[0] !== 1'b0 || pwm !== m_pwm) begin
            bad++; $display("FAIL presc cyc %0d: got pwm=%b want pwm1=%b pwm0=0", i, pwm, e);
         end
      end
   endtask

   task automatic test_misc();
      logic [31:0] v, e;
      rd(8'h3C, v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL unmapped_rd: got %0h want 0", v); end
      wr(8'h10, 32'hFFFF_1234);
      rd(8'h10, v);
      total++;
      if (v !== 32'h1234) begin bad++; $display("FAIL per_trunc: got %0h want 1234", v); end
      wr(8'h3C, 32'hFFFF_FFFF);
      e = m_read(8'h00);
      rd(8'h00, v);
      total++;
      if (v !== e || v !== 32'h2) begin bad++; $display("FAIL unmapped_wr: got %0h want 2", v); end
   endtask

   task automatic test_random();
      int op, idx;
      logic [31:0] d, v, e;
      logic [7:0] a;
      apply_reset();
      for (int it = 0; it < 1500; it++) begin
         op = $urandom_range(0, 19);
         idx = $urandom_range(0, 15);
         a = 8'(idx * 4);
         if (op >= 17) begin
            e = m_read(a);
            rd(a, v);
            total++;
            if (v !== e) begin bad++; $display("FAIL rand_rd it %0d a=%0h: got %0h want %0h", it, a, v, e); end
         end else begin
            if (op >= 12) begin
               case (idx)
                  0:       d = $urandom_range(0, 15);
                  1:       d = $urandom_range(0, 3);
                  2, 3:    d = $urandom_range(0, 15);
                  default: d = (idx < 12) ? 32'($urandom_range(0, 8)) : $urandom;
               endcase
               wr(a, d);
            end else begin
               step();
            end
            total++;
            if (pwm !== m_pwm || intr !== m_intr) begin
               bad++; $display("FAIL rand it %0d: got pwm=%b intr=%b want pwm=%b intr=%b",
                               it, pwm, intr, m_pwm, m_intr);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      int k;
      wr(8'h04, 0); wr(8'h10, 3); wr(8'h14, 2); wr(8'h0C, 1); wr(8'h00, 1);
      for (k = 0; k < 10 && pwm[0] !== 1'b1; k++) step();
      total++;
      if (pwm[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_wait: got pwm0=%b want 1", pwm[0]); end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (pwm !== '0 || intr !== 1'b0) begin
         bad++; $display("FAIL rst_mid_async: got pwm=%b intr=%b want 0 0", pwm, intr);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      rd(8'h00, v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL rst_mid_ctrl: got %0h want 0", v); end
      repeat (4) step();
      total++;
      if (pwm !== '0 || intr !== 1'b0) begin
         bad++; $display("FAIL rst_mid_idle: got pwm=%b intr=%b want 0 0", pwm, intr);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_intr();
      test_shadow();
      test_presc();
      test_misc();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
